// File: rtl/axis_pkg.sv
// Shared definitions for the packet arbiter: default geometry and FSM encoding.
package axis_pkg;

  localparam int DEF_N_PORTS      = 7;
  localparam int DEF_WEIGHT_WIDTH = 4;
  localparam int DEF_IDX_WIDTH    = 3;

  // IDLE searches for a new owner, BUSY carries one packet,
  // NEXT decides whether the owner keeps the grant for another packet.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_NEXT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// Arbiter bundle: request/config inputs, observed output-beat handshake and
// the registered grant. The slave modport is the arbiter, the master modport
// is the surrounding switch fabric.
interface axis_pkt_arbiter_if #(
  parameter int N_PORTS      = axis_pkg::DEF_N_PORTS,
  parameter int WEIGHT_WIDTH = axis_pkg::DEF_WEIGHT_WIDTH,
  parameter int IDX_WIDTH    = axis_pkg::DEF_IDX_WIDTH
);

  logic [N_PORTS-1:0]              req;
  logic [N_PORTS-1:0]              cfg_enable;
  logic [N_PORTS*WEIGHT_WIDTH-1:0] cfg_weight;
  logic                            m_tvalid;
  logic                            m_tready;
  logic                            m_tlast;
  logic [N_PORTS-1:0]              grant;
  logic [IDX_WIDTH-1:0]            grant_idx;
  logic                            grant_valid;

  modport master (
    output req, cfg_enable, cfg_weight, m_tvalid, m_tready, m_tlast,
    input  grant, grant_idx, grant_valid
  );

  modport slave (
    input  req, cfg_enable, cfg_weight, m_tvalid, m_tready, m_tlast,
    output grant, grant_idx, grant_valid
  );

endinterface

// File: rtl/axis_pkt_arbiter_rr_search.sv
// Round-robin first-eligible search. Purely combinational so the whole ring
// is scanned in a single cycle no matter how many ports are skipped.
module rr_search import axis_pkg::*; #(
  parameter int N_PORTS   = DEF_N_PORTS,
  parameter int IDX_WIDTH = DEF_IDX_WIDTH
) (
  input  logic [N_PORTS-1:0]   eligible,
  input  logic [IDX_WIDTH-1:0] start,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] idx
);

  int                   pos;
  logic [IDX_WIDTH-1:0] cand;

  // Visit every port once beginning at start, wrapping past the top port;
  // the first eligible one wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave a value held and infer a latch.
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    cand  = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      pos = int'(start) + k;
      if (pos >= N_PORTS) pos = pos - N_PORTS;
      cand = IDX_WIDTH'(pos);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Weighted round-robin packet arbiter. A port keeps its grant for up to
// cfg_weight whole packets (0 counts as 1) and is never preempted mid-packet.
// Downstream datapaths mux on grant_idx and gate each FIFO tready with grant.
module axis_pkt_arbiter import axis_pkg::*; #(
  parameter int N_PORTS      = DEF_N_PORTS,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int IDX_WIDTH    = DEF_IDX_WIDTH
) (
  input logic              aclk,
  input logic              aresetn,
  axis_pkt_arbiter_if.slave bus
);

  localparam logic [IDX_WIDTH-1:0] LAST_PORT = IDX_WIDTH'(N_PORTS - 1);

  arb_state_t              state, state_n;
  logic [WEIGHT_WIDTH-1:0] credit, credit_n;
  logic [IDX_WIDTH-1:0]    last_idx, last_idx_n;
  logic [N_PORTS-1:0]      grant_q, grant_n;
  logic [IDX_WIDTH-1:0]    grant_idx_q, grant_idx_n;
  logic                    grant_valid_q, grant_valid_n;

  logic [N_PORTS-1:0]      eligible;
  logic [IDX_WIDTH-1:0]    start_idx;
  logic                    found;
  logic [IDX_WIDTH-1:0]    found_idx;
  logic [WEIGHT_WIDTH-1:0] found_weight;
  logic                    last_beat;

  assign eligible     = bus.req & bus.cfg_enable;
  assign start_idx    = (last_idx == LAST_PORT) ? '0 : last_idx + 1'b1;
  assign found_weight = bus.cfg_weight[int'(found_idx) * WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign last_beat    = bus.m_tvalid & bus.m_tready & bus.m_tlast;

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;

  rr_search #(
    .N_PORTS   (N_PORTS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr_search (
    .eligible (eligible),
    .start    (start_idx),
    .found    (found),
    .idx      (found_idx)
  );

  // State and grant registers; reset parks last_idx on the top port so the
  // first search after reset starts at port 0.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      credit        <= '0;
      last_idx      <= LAST_PORT;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every register samples pre-edge values,
      // independent of statement order.
      state         <= state_n;
      credit        <= credit_n;
      last_idx      <= last_idx_n;
      grant_q       <= grant_n;
      grant_idx_q   <= grant_idx_n;
      grant_valid_q <= grant_valid_n;
    end
  end

  // Next-state logic: grant on search hit, spend one credit per last beat,
  // keep the owner between packets only while it stays eligible.
  always_comb begin
    state_n       = state;
    credit_n      = credit;
    last_idx_n    = last_idx;
    grant_n       = grant_q;
    grant_idx_n   = grant_idx_q;
    grant_valid_n = grant_valid_q;
    unique case (state)
      ST_IDLE: begin
        grant_n       = '0;
        grant_valid_n = 1'b0;
        if (found) begin
          state_n       = ST_BUSY;
          grant_n       = N_PORTS'(1) << found_idx;
          grant_idx_n   = found_idx;
          grant_valid_n = 1'b1;
          credit_n      = (found_weight == '0) ? WEIGHT_WIDTH'(1) : found_weight;
        end
      end
      ST_BUSY: begin
        if (last_beat) begin
          credit_n   = (credit == '0) ? '0 : credit - 1'b1;
          last_idx_n = grant_idx_q;
          if (credit_n == '0) begin
            state_n       = ST_IDLE;
            grant_n       = '0;
            grant_valid_n = 1'b0;
          end else begin
            state_n = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (eligible[grant_idx_q]) begin
          state_n = ST_BUSY;
        end else begin
          state_n       = ST_IDLE;
          grant_n       = '0;
          grant_valid_n = 1'b0;
        end
      end
      default: begin
        state_n       = ST_IDLE;
        grant_n       = '0;
        grant_valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter: directed scenarios followed by
// randomized turns predicted by a packet-level round-robin model.
module tb_axis_pkt_arbiter;

  localparam int N  = 7;
  localparam int WW = 4;
  localparam int IW = 3;

  logic aclk;
  logic aresetn;
  int   checks = 0;
  int   errors = 0;
  int   mdl_last;

  axis_pkt_arbiter_if #(.N_PORTS(N), .WEIGHT_WIDTH(WW), .IDX_WIDTH(IW)) bus ();

  axis_pkt_arbiter #(.N_PORTS(N), .WEIGHT_WIDTH(WW), .IDX_WIDTH(IW)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge aclk);
  endtask

  // port < 0 means no grant expected.
  task automatic expect_grant(input string tag, input int port);
    logic [N-1:0] oh;
    oh = '0;
    if (port >= 0) oh[port] = 1'b1;
    check({tag, ".grant"}, 32'(bus.grant), 32'(oh));
    check({tag, ".valid"}, 32'(bus.grant_valid), 32'(port >= 0));
    if (port >= 0) check({tag, ".idx"}, 32'(bus.grant_idx), 32'(port));
  endtask

  task automatic set_weight(input int p, input int w);
    bus.cfg_weight[p*WW +: WW] = WW'(w);
  endtask

  function automatic int weight_of(input int p);
    return int'(bus.cfg_weight[p*WW +: WW]);
  endfunction

  // Reference rule: first eligible port after 'last', wrapping around the ring.
  function automatic int first_from(input logic [N-1:0] elig, input int last);
    for (int k = 1; k <= N; k++)
      if (elig[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic idle_beat();
    bus.m_tvalid = 1'b0;
    bus.m_tready = 1'b0;
    bus.m_tlast  = 1'b0;
  endtask

  task automatic scramble();
    bus.req        = N'($urandom);
    bus.cfg_enable = N'($urandom | $urandom);
    bus.cfg_weight = (N*WW)'({$urandom, $urandom});
  endtask

  // Drives one packet for the granted port; grant must hold through gaps and
  // non-last beats. The caller checks the outcome of the last beat.
  task automatic send_pkt(input string tag, input int port, input int beats,
                          input bit noisy, input bit drop_en);
    for (int b = 0; b < beats; b++) begin
      if (noisy) begin
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
          bus.m_tlast = 1'($urandom);
          if ($urandom_range(0, 1) == 0) begin
            bus.m_tvalid = 1'b0;
            bus.m_tready = 1'($urandom);
          end else begin
            bus.m_tvalid = 1'b1;
            bus.m_tready = 1'b0;
          end
          scramble();
          step();
          expect_grant({tag, ".gap"}, port);
        end
      end
      bus.m_tvalid = 1'b1;
      bus.m_tready = 1'b1;
      bus.m_tlast  = (b == beats - 1);
      if (noisy) scramble();
      step();
      if (drop_en && b == 0) bus.cfg_enable[port] = 1'b0;
      if (b != beats - 1) expect_grant({tag, ".hold"}, port);
    end
    idle_beat();
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    aresetn        = 1'b0;
    bus.req        = '0;
    bus.cfg_enable = '1;
    bus.cfg_weight = '0;
    idle_beat();
    step();
    expect_grant("reset", -1);
    check("reset.idx", 32'(bus.grant_idx), 32'd0);
    aresetn  = 1'b1;
    mdl_last = N - 1;
  endtask

  initial begin
    int exp_port;
    int credits;
    int w;
    bit elig_now;

    aresetn        = 1'b0;
    bus.req        = '0;
    bus.cfg_enable = '0;
    bus.cfg_weight = '0;
    idle_beat();

    // Single requester, weight 2, two 3-beat packets.
    apply_reset();
    set_weight(0, 2);
    bus.req = 7'b0000001;
    step(); expect_grant("single.grant", 0);
    send_pkt("single.p1", 0, 3, 1'b0, 1'b0);
    expect_grant("single.next", 0);
    step(); expect_grant("single.busy", 0);
    send_pkt("single.p2", 0, 3, 1'b0, 1'b0);
    expect_grant("single.idle", -1);
    step(); expect_grant("single.regrant", 0);

    // All ports requesting, weight 1: strict rotation 0..6 then back to 0.
    apply_reset();
    for (int p = 0; p < N; p++) set_weight(p, 1);
    bus.req = '1;
    for (int t = 0; t <= N; t++) begin
      step(); expect_grant($sformatf("rr.%0d", t), t % N);
      send_pkt("rr.pkt", t % N, 2, 1'b0, 1'b0);
      expect_grant("rr.idle", -1);
    end

    // Ports 0 and 6: after port 0 comes 6, then wrap back to 0.
    apply_reset();
    set_weight(0, 1);
    set_weight(6, 1);
    bus.req = 7'b1000001;
    step(); expect_grant("wrap.first", 0);
    send_pkt("wrap.p0", 0, 1, 1'b0, 1'b0);
    expect_grant("wrap.idle0", -1);
    step(); expect_grant("wrap.hi", 6);
    send_pkt("wrap.p6", 6, 2, 1'b0, 1'b0);
    expect_grant("wrap.idle6", -1);
    step(); expect_grant("wrap.lo", 0);

    // Port 2 loses enable mid-packet: kept to tlast, then released to port 4.
    apply_reset();
    set_weight(2, 3);
    set_weight(4, 1);
    bus.req = 7'b0010100;
    step(); expect_grant("drop.grant", 2);
    send_pkt("drop.pkt", 2, 4, 1'b0, 1'b1);
    expect_grant("drop.next", 2);
    step(); expect_grant("drop.idle", -1);
    step(); expect_grant("drop.other", 4);

    // Weight 0 gives one packet; a weight change applies only at next load.
    apply_reset();
    set_weight(3, 0);
    bus.req = 7'b0001000;
    step(); expect_grant("w0.grant", 3);
    send_pkt("w0.p1", 3, 2, 1'b0, 1'b0);
    expect_grant("w0.idle", -1);
    step(); expect_grant("w0.regrant", 3);
    set_weight(3, 15);
    send_pkt("w0.p2", 3, 2, 1'b0, 1'b0);
    expect_grant("w0.one", -1);
    step(); expect_grant("w15.grant", 3);
    for (int k = 0; k < 15; k++) begin
      send_pkt("w15.pkt", 3, 2, 1'b0, 1'b0);
      if (k < 14) begin
        expect_grant("w15.next", 3);
        step(); expect_grant("w15.busy", 3);
      end
    end
    expect_grant("w15.idle", -1);
    step(); expect_grant("w15.regrant", 3);

    // Reset mid-packet of port 3 drops the grant at once; restart at port 0.
    apply_reset();
    set_weight(0, 1);
    set_weight(3, 1);
    bus.req = 7'b0001001;
    step(); expect_grant("arst.p0", 0);
    send_pkt("arst.pkt0", 0, 1, 1'b0, 1'b0);
    expect_grant("arst.idle", -1);
    step(); expect_grant("arst.p3", 3);
    bus.m_tvalid = 1'b1;
    bus.m_tready = 1'b1;
    bus.m_tlast  = 1'b0;
    step(); expect_grant("arst.mid", 3);
    #2 aresetn = 1'b0;
    #1 expect_grant("arst.async", -1);
    check("arst.idx", 32'(bus.grant_idx), 32'd0);
    idle_beat();
    @(negedge aclk);
    aresetn = 1'b1;
    step(); expect_grant("arst.restart", 0);

    // Randomized turns against the packet-level model.
    apply_reset();
    for (int r = 0; r < 40; r++) begin
      scramble();
      exp_port = first_from(bus.req & bus.cfg_enable, mdl_last);
      step();
      if (exp_port < 0) begin
        expect_grant("rnd.none", -1);
        continue;
      end
      expect_grant("rnd.grant", exp_port);
      w       = weight_of(exp_port);
      credits = (w == 0) ? 1 : w;
      forever begin
        send_pkt("rnd.pkt", exp_port, int'($urandom_range(1, 3)), 1'b1, 1'b0);
        credits--;
        mdl_last = exp_port;
        if (credits == 0) begin
          expect_grant("rnd.done", -1);
          break;
        end
        expect_grant("rnd.next", exp_port);
        if ($urandom_range(0, 3) == 0) bus.cfg_enable[exp_port] = 1'b0;
        elig_now = bus.req[exp_port] & bus.cfg_enable[exp_port];
        step();
        if (elig_now) begin
          expect_grant("rnd.cont", exp_port);
        end else begin
          expect_grant("rnd.drop", -1);
          break;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
